reg_operand_fetch: RTL
======================

// Module: reg_operand_fetch
// PURPOSE
//  Read side of the register file for the pipelined MIPS core; sits in the ID stage between decode and EX.
//  Drives RegFile read addresses and keeps a per-register scoreboard of in-flight writers.
//  Forwards EX/MEM and WB results, stalls decode when an operand is not yet available, and
//  registers resolved operands into a valid/ready handshake towards EX.
// PARAMETERS
//  DW      32  data width
//  AW      5   register address width (2**AW registers; r0 hardwired zero)
//  CNT_W   2   scoreboard counter width per register; max in-flight writers per reg = 2**CNT_W-1
// PORTS
//  Clk           in   1    clock, posedge (RegFile writes on negedge)
//  Rst           in   1    reset, synchronous, active-high
//  id_valid      in   1    decoded instruction present
//  id_ready      out  1    accepted this cycle when id_valid && id_ready
//  id_rs,id_rt   in   AW   source register numbers
//  id_use_rs/rt  in   1    source actually read
//  id_rd         in   AW   destination register
//  id_wen        in   1    instruction writes id_rd
//  rf_a1,rf_a2   out  AW   RegFile read addresses (= id_rs, id_rt, combinational)
//  rf_rd1,rf_rd2 in   DW   RegFile read data
//  em_fwd_valid  in   1    EX/MEM result valid for forwarding
//  em_fwd_addr   in   AW   EX/MEM destination
//  em_fwd_data   in   DW   EX/MEM result
//  wb_we,wb_addr,wb_data  in 1/AW/DW  writeback bus (same bus feeds RegFile We/A3/WD)
//  flush         in   1    kill instruction held in output register
//  ex_valid      out  1    operands valid towards EX
//  ex_ready      in   1    EX accepts
//  ex_rs_val,ex_rt_val out DW resolved operands
//  ex_rd, ex_wen out  AW/1 registered destination info
// BEHAVIOUR
//  Reset: all pend[r]=0, ex_valid=0, ex_rs_val=ex_rt_val=0, ex_rd=0, ex_wen=0. Rst wins over all events.
//  Operand resolution per source s (unused source = ready, value 0):
//   s==0 -> ready, value 0
//   pend[s]==0 -> ready, RegFile data
//   pend[s]==1 && em_fwd_valid && em_fwd_addr==s -> ready, em_fwd_data (priority over WB)
//   pend[s]==1 && wb_we && wb_addr==s -> ready, wb_data
//   otherwise not ready (incl. pend>=2: newest writer unknown)
//  Writer stall: id_wen && id_rd!=0 && pend[id_rd]==max -> not ready.
//  slot_free = !ex_valid || ex_ready || flush.
//  id_ready = both operands ready && no writer stall && slot_free; combinational.
//  Accept (id_valid && id_ready): next cycle ex_valid=1, ex_* loaded with resolved values; latency 1.
//  Hold: ex_valid && !ex_ready && !flush -> all ex_* stable.
//  Drain: ex_ready && no accept -> ex_valid=0.
//  Flush: ex_valid cleared unless a same-cycle accept reloads it; flushed instr with ex_wen && ex_rd!=0
//   decrements pend[ex_rd] (it never writes back).
//  Scoreboard per r!=0, per cycle: +1 on accept with id_wen && id_rd==r; -1 on wb_we && wb_addr==r;
//   -1 on flush of writer to r; all terms summed (inc and dec same reg same cycle -> unchanged).
//   Never underflows: stray WB to a reg with pend==0 is ignored. r0 counter constant 0.
// TESTING
//  1 Reset, id_rs=29,id_rt=28, no writers -> ex_valid 1 cycle after accept, ex_rs_val=0x2ffc, ex_rt_val=0x1800.
//  2 Issue writer rd=5, next instr reads r5; em_fwd_valid=1,addr=5,data=0xA5A5 -> no stall, ex_rs_val=0xA5A5; pend[5] back to 0 after WB.
//  3 Reader of r7 with pend[7]=1, no forward for 3 cycles -> id_ready=0 for 3 cycles; wb_we addr=7 data=0x1234 -> accept, value 0x1234.
//  4 Two writers to r9 in flight (pend=2), reader of r9 with em forward present -> stall until one WB (pend=1), then forward.
//  5 ex_ready=0 for 4 cycles -> ex_* stable, id_ready=0; then flush with ex_wen,ex_rd=3 -> ex_valid=0, pend[3] decremented.
//  6 Simultaneous accept writer rd=4 and wb_we addr=4 with pend[4]=1 -> pend[4]=1; assert Rst mid-stall -> ex_valid=0, all pend 0 next cycle.

Source files
------------

// File: rtl/reg_operand_fetch_if.sv
// Operand-fetch port bundle: ID-side request, RegFile read port, bypass buses and EX-side handshake.
// slave is the fetch stage's view; master is the surrounding pipeline's view.
interface reg_operand_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_rd;
    logic          id_wen;
    logic [AW-1:0] rf_a1;
    logic [AW-1:0] rf_a2;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic          em_fwd_valid;
    logic [AW-1:0] em_fwd_addr;
    logic [DW-1:0] em_fwd_data;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_rs_val;
    logic [DW-1:0] ex_rt_val;
    logic [AW-1:0] ex_rd;
    logic          ex_wen;

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wen,
        input  rf_rd1, rf_rd2,
        input  em_fwd_valid, em_fwd_addr, em_fwd_data,
        input  wb_we, wb_addr, wb_data,
        input  flush, ex_ready,
        output id_ready, rf_a1, rf_a2,
        output ex_valid, ex_rs_val, ex_rt_val, ex_rd, ex_wen
    );

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wen,
        output rf_rd1, rf_rd2,
        output em_fwd_valid, em_fwd_addr, em_fwd_data,
        output wb_we, wb_addr, wb_data,
        output flush, ex_ready,
        input  id_ready, rf_a1, rf_a2,
        input  ex_valid, ex_rs_val, ex_rt_val, ex_rd, ex_wen
    );
endinterface

// File: rtl/reg_operand_fetch.sv
// ID-stage operand fetch: register scoreboard, EX/MEM and WB bypass, decode stall,
// and a single output register towards EX with valid/ready handshake and flush.
module reg_operand_fetch #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    reg_operand_fetch_if.slave  bus
);
    localparam int NREG = 1 << AW;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0] pend [NREG];

    logic [DW:0]   rs_res;
    logic [DW:0]   rt_res;
    logic          writer_stall;
    logic          slot_free;
    logic          accept;
    logic          flush_kill;

    logic          vld_p1;
    logic [DW-1:0] rs_val_p1;
    logic [DW-1:0] rt_val_p1;
    logic [AW-1:0] rd_p1;
    logic          wen_p1;

    // {ready, value}. With two or more writers in flight the bypassed value may
    // belong to an older writer, so only a single pending writer may be bypassed.
    function automatic logic [DW:0] resolve(
        input logic          use_s,
        input logic [AW-1:0] s,
        input logic [CNT_W-1:0] p,
        input logic [DW-1:0] rf_d,
        input logic          em_v,
        input logic [AW-1:0] em_a,
        input logic [DW-1:0] em_d,
        input logic          wb_v,
        input logic [AW-1:0] wb_a,
        input logic [DW-1:0] wb_d
    );
        if (!use_s || s == '0)
            return {1'b1, {DW{1'b0}}};
        if (p == '0)
            return {1'b1, rf_d};
        if (p == CNT_W'(1)) begin
            if (em_v && em_a == s)
                return {1'b1, em_d};
            if (wb_v && wb_a == s)
                return {1'b1, wb_d};
        end
        return {1'b0, {DW{1'b0}}};
    endfunction

    // Counter update saturating at both ends; a writeback to an idle register is ignored.
    function automatic logic [CNT_W-1:0] sb_next(
        input logic [CNT_W-1:0] p,
        input logic             inc,
        input logic             dec_wb,
        input logic             dec_fl
    );
        logic signed [CNT_W+1:0] sum;
        sum = $signed({2'b00, p})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec_wb && (p != '0)})
            - $signed({{(CNT_W+1){1'b0}}, dec_fl});
        if (sum[CNT_W+1])
            return '0;
        if (sum[CNT_W])
            return PEND_MAX;
        return sum[CNT_W-1:0];
    endfunction

    assign bus.rf_a1 = bus.id_rs;
    assign bus.rf_a2 = bus.id_rt;

    always_comb begin
        rs_res = resolve(bus.id_use_rs, bus.id_rs, pend[bus.id_rs], bus.rf_rd1,
                         bus.em_fwd_valid, bus.em_fwd_addr, bus.em_fwd_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data);
        rt_res = resolve(bus.id_use_rt, bus.id_rt, pend[bus.id_rt], bus.rf_rd2,
                         bus.em_fwd_valid, bus.em_fwd_addr, bus.em_fwd_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data);
        writer_stall = bus.id_wen && (bus.id_rd != '0) && (pend[bus.id_rd] == PEND_MAX);
        slot_free    = !vld_p1 || bus.ex_ready || bus.flush;
        bus.id_ready = rs_res[DW] && rt_res[DW] && !writer_stall && slot_free;
        accept       = bus.id_valid && bus.id_ready;
        flush_kill   = bus.flush && vld_p1 && wen_p1 && (rd_p1 != '0);
    end

    // Scoreboard: one in-flight-writer counter per architectural register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int r = 0; r < NREG; r++)
                pend[r] <= '0;
        end else begin
            pend[0] <= '0;
            for (int r = 1; r < NREG; r++)
                pend[r] <= sb_next(pend[r],
                                   accept && bus.id_wen && (bus.id_rd == r[AW-1:0]),
                                   bus.wb_we && (bus.wb_addr == r[AW-1:0]),
                                   flush_kill && (rd_p1 == r[AW-1:0]));
        end
    end

    // Stage p1: resolved operands held for EX.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p1    <= 1'b0;
            rs_val_p1 <= '0;
            rt_val_p1 <= '0;
            rd_p1     <= '0;
            wen_p1    <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            rs_val_p1 <= rs_res[DW-1:0];
            rt_val_p1 <= rt_res[DW-1:0];
            rd_p1     <= bus.id_rd;
            wen_p1    <= bus.id_wen;
        end else if (bus.ex_ready || bus.flush) begin
            vld_p1    <= 1'b0;
        end
    end

    assign bus.ex_valid  = vld_p1;
    assign bus.ex_rs_val = rs_val_p1;
    assign bus.ex_rt_val = rt_val_p1;
    assign bus.ex_rd     = rd_p1;
    assign bus.ex_wen    = wen_p1;
endmodule
